// File: rtl/reg_file_bank.sv
// Parametrised register file: one write port, two combinational read ports, one-cycle
// checkpoint shadow bank, dirty flag. Optional macro REG_FILE_WRITE_BYPASS_EN adds write-to-read forwarding.

module reg_file_bank_cell #(
    parameter int WIDTH   = 32,
    parameter bit IS_ZERO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             snapshot,
    input  logic             restore,
    output logic [WIDTH-1:0] live_q
);
    logic [WIDTH-1:0] live_d;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;

    always_comb begin
        live_d   = live_q;
        shadow_d = shadow_q;
        if (restore) live_d = shadow_q;
        // A same-cycle write wins over the restored value for this register.
        if (wr_en) live_d = wr_data;
        if (snapshot && !restore) shadow_d = live_q;
        if (IS_ZERO) begin
            live_d   = '0;
            shadow_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live_q   <= '0;
            shadow_q <= '0;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
        end
    end
endmodule

module reg_file_bank #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             writeEnable,
    input  logic [AW-1:0]    writeAddr,
    input  logic [WIDTH-1:0] writeData,
    input  logic [AW-1:0]    readAddr1,
    output logic [WIDTH-1:0] readData1,
    input  logic [AW-1:0]    readAddr2,
    output logic [WIDTH-1:0] readData2,
    input  logic             snapshot,
    input  logic             restore,
    output logic             dirty
);
    logic [DEPTH-1:0][WIDTH-1:0] live;
    logic                        wr_eff;
    logic                        dirty_q;
    logic                        dirty_d;

    // Writes to the hardwired zero register are dropped before they reach the cells or dirty.
    assign wr_eff = writeEnable && !((ZERO_REG != 0) && (writeAddr == '0));

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        localparam bit IS_ZERO = (i == 0) && (ZERO_REG != 0);
        reg_file_bank_cell #(
            .WIDTH  (WIDTH),
            .IS_ZERO(IS_ZERO)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_eff && (writeAddr == AW'(i))),
            .wr_data (writeData),
            .snapshot(snapshot),
            .restore (restore),
            .live_q  (live[i])
        );
    end

    always_comb begin
        dirty_d = dirty_q;
        if (snapshot || restore) dirty_d = 1'b0;
        if (wr_eff) dirty_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dirty_q <= 1'b0;
        else      dirty_q <= dirty_d;
    end

    assign dirty = dirty_q;

    always_comb begin
        readData1 = live[readAddr1];
        readData2 = live[readAddr2];
`ifdef REG_FILE_WRITE_BYPASS_EN
        if (writeEnable && (readAddr1 == writeAddr)) readData1 = writeData;
        if (writeEnable && (readAddr2 == writeAddr)) readData2 = writeData;
`endif
        if ((ZERO_REG != 0) && (readAddr1 == '0)) readData1 = '0;
        if ((ZERO_REG != 0) && (readAddr2 == '0)) readData2 = '0;
    end
endmodule

// File: doc/reg_file_bank.md
Name: reg_file_bank

Overview:
- Parametrised register file for the single-cycle datapath: DEPTH words of WIDTH bits, one write port, two asynchronous read ports.
- Successor to the single-bit write-enabled storage cell: same write-enable semantics, generalised in width and depth.
- Adds a one-cycle checkpoint shadow bank (snapshot/restore), a dirty flag, and an optional hardwired-zero register.
- Sits between the controller (writeEnable, snapshot, restore) and the ALU operand muxes.

Parameters:
WIDTH, 32, bits per register
DEPTH, 32, number of registers; power of two, >= 2
ZERO_REG, 1, 1: register 0 always reads 0 and ignores writes; 0: register 0 is ordinary
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
writeEnable  input  1  write strobe for writeAddr/writeData
writeAddr  input  AW  destination register index
writeData  input  WIDTH  data to write
readAddr1  input  AW  read port 1 index
readData1  output  WIDTH  read port 1 data (combinational)
readAddr2  input  AW  read port 2 index
readData2  output  WIDTH  read port 2 data (combinational)
snapshot  input  1  copy all live registers into shadow bank
restore  input  1  copy shadow bank back into live registers
dirty  output  1  high when a live register has been written since the last snapshot/restore/reset

Behaviour:
- Reset (rst low, asynchronous):
  - All live registers, all shadow registers and dirty clear to 0 immediately, independent of clk.
  - State is held at 0 while rst is low; normal operation resumes on the first rising edge after rst rises.
- Read ports:
  - Purely combinational, 0-cycle latency.
  - readDataN = live[readAddrN].
  - With ZERO_REG=1 and readAddrN==0, readDataN = 0.
- Write:
  - On a rising edge with writeEnable=1, live[writeAddr] <= writeData.
  - New value visible on read ports after that edge.
  - writeEnable=0 leaves every register unchanged.
  - With ZERO_REG=1, a write to address 0 is discarded and does not set dirty.
- Snapshot:
  - On a rising edge with snapshot=1 and restore=0, shadow[i] <= live[i] for all i.
  - The shadow captures pre-edge values; a same-cycle write is not captured.
  - The same-cycle write still updates the live register and sets dirty.
- Restore:
  - On a rising edge with restore=1, live[i] <= shadow[i] for all i.
  - A same-cycle write to writeAddr takes priority for that one register: live[writeAddr] <= writeData.
  - dirty = 1 if that write is effective, else 0.
- Snapshot and restore in the same cycle: restore executes, snapshot is ignored, shadow is unchanged.
- dirty update priority, highest first, evaluated on each rising edge:
  1. Effective write (writeEnable=1, and not to address 0 when ZERO_REG=1) -> dirty <= 1.
  2. Snapshot or restore -> dirty <= 0.
  3. Otherwise dirty holds.
- Shadow register 0 follows the same ZERO_REG rule: it always holds 0 when ZERO_REG=1.
- Out-of-range addresses are impossible because DEPTH is a power of two.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN
- Defined:
  - Each read port forwards writeData combinationally when writeEnable=1 and readAddrN==writeAddr.
  - ZERO_REG still forces 0 at address 0.
  - Forwarding takes priority over the live value, even in a restore cycle.
- Undefined: reads always return the pre-edge live value; no forwarding path is synthesised.

Test Plan:
- Reset: write 0xDEADBEEF to r5, drop rst mid-cycle -> readData1(r5)=0 before the next edge; dirty=0.
- Write/read: write r3=0x12345678, r7=0xFFFFFFFF on consecutive edges; read r3/r7 on both ports -> exact values. Write r0=0xAAAA5555 with ZERO_REG=1 -> r0 reads 0, dirty unchanged.
- Snapshot/restore: r4=0x11 -> snapshot -> r4=0x22 (dirty=1) -> restore -> r4=0x11, dirty=0.
- Simultaneous snapshot+write r4=0x33 with r4=0x11 -> shadow r4=0x11, live r4=0x33, dirty=1.
- Simultaneous restore+write r9=0x99 with shadow r9=0x01 and shadow r2=0x02 -> r9=0x99, r2=0x02, dirty=1. Restore+snapshot together -> shadow unchanged.
- Bypass: with REG_FILE_WRITE_BYPASS_EN, writeEnable=1, writeAddr=6, writeData=0xCAFE, readAddr1=6 -> readData1=0xCAFE in the same cycle. Without the macro, readData1 shows the old r6 until after the edge.
